// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
//
// Write-back scheduler and hazard scoreboard for a single-write-port RegFile.
// It arbitrates two write-back requesters (ALU and load unit) onto the one
// write port using round-robin priority. It also keeps a per-register
// pending-write scoreboard and stalls issue on RAW and WAW hazards.
//
// Ports
//   clk, rst                      clock; synchronous active-high reset
//   issue_valid/rs1/rs2/rd        instruction presented by the issue stage
//   issue_stall                   combinational; 1 = the instruction is not accepted
//   wb0_valid/rd/data, wb0_ready  requester 0 (ALU) write-back handshake
//   wb1_valid/rd/data, wb1_ready  requester 1 (load unit) write-back handshake
//   rf_r, rf_rd, rf_din           RegFile write port; rf_r=0 means write this cycle
//   busy_mask                     registered scoreboard; bit i = write to reg i pending
//   wb_err                        sticky flag: a write-back hit a register that was not busy

module regfile_wb_sched #(
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_stall,
    input  logic            wb0_valid,
    input  logic [AW-1:0]   wb0_rd,
    input  logic [DW-1:0]   wb0_data,
    output logic            wb0_ready,
    input  logic            wb1_valid,
    input  logic [AW-1:0]   wb1_rd,
    input  logic [DW-1:0]   wb1_data,
    output logic            wb1_ready,
    output logic            rf_r,
    output logic [AW-1:0]   rf_rd,
    output logic [DW-1:0]   rf_din,
    output logic [NREG-1:0] busy_mask,
    output logic            wb_err
);

    // Round-robin owner: 0 means wb0 wins a tie, 1 means wb1 wins a tie.
    logic            rr_ptr;
    logic            acc_valid;
    logic [AW-1:0]   acc_rd;
    logic [DW-1:0]   acc_data;
    logic            acc_write;
    logic            issue_accept;
    logic [NREG-1:0] busy_next;

    // Grants are held low during reset. This keeps a requester from treating a
    // discarded write as consumed, so it re-arbitrates once reset is released.
    always_comb begin
        wb0_ready = 1'b0;
        wb1_ready = 1'b0;
        if (!rst) begin
            if (wb0_valid && wb1_valid) begin
                wb0_ready = !rr_ptr;
                wb1_ready = rr_ptr;
            end else begin
                wb0_ready = wb0_valid;
                wb1_ready = wb1_valid;
            end
        end
    end

    // Select the accepted write-back. At most one grant is high in any cycle.
    always_comb begin
        acc_valid = (wb0_valid && wb0_ready) || (wb1_valid && wb1_ready);
        acc_rd    = wb1_ready ? wb1_rd : wb0_rd;
        acc_data  = wb1_ready ? wb1_data : wb0_data;
        // A write to register 0 is consumed but never reaches the RegFile.
        acc_write = acc_valid && (acc_rd != '0);
    end

    // Hazard detection. busy_mask[0] is always 0, so source register 0 never
    // stalls, and the rd check is written to make register 0 explicit.
    always_comb begin
        issue_stall  = issue_valid && (busy_mask[issue_rs1] || busy_mask[issue_rs2] ||
                       ((issue_rd != '0) && busy_mask[issue_rd]));
        issue_accept = issue_valid && !issue_stall;
    end

    // Scoreboard update. The clear from the RegFile commit is applied first, so
    // a newly issued producer of the same register wins on the same edge.
    always_comb begin
        busy_next = busy_mask;
        if (!rf_r) begin
            busy_next[rf_rd] = 1'b0;
        end
        if (issue_accept && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Register the write port, the scoreboard, the error flag and the round-robin
    // pointer. The pointer flips only after a grant taken while both requesters
    // were competing.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_r      <= 1'b1;
            rf_rd     <= '0;
            rf_din    <= '0;
            busy_mask <= '0;
            wb_err    <= 1'b0;
            rr_ptr    <= 1'b0;
        end else begin
            busy_mask <= busy_next;
            rf_r      <= !acc_write;
            if (acc_write) begin
                rf_rd  <= acc_rd;
                rf_din <= acc_data;
                if (!busy_mask[acc_rd]) begin
                    wb_err <= 1'b1;
                end
            end
            if (wb0_valid && wb1_valid && acc_valid) begin
                rr_ptr <= !rr_ptr;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched
//
// Directed testbench for regfile_wb_sched. A small RegFile model captures each
// committed write so that values read after a hazard stall can be checked.

module tb_regfile_wb_sched;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic            clk;
    logic            rst;
    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            issue_stall;
    logic            wb0_valid;
    logic [AW-1:0]   wb0_rd;
    logic [DW-1:0]   wb0_data;
    logic            wb0_ready;
    logic            wb1_valid;
    logic [AW-1:0]   wb1_rd;
    logic [DW-1:0]   wb1_data;
    logic            wb1_ready;
    logic            rf_r;
    logic [AW-1:0]   rf_rd;
    logic [DW-1:0]   rf_din;
    logic [NREG-1:0] busy_mask;
    logic            wb_err;

    int checks;
    int errors;

    logic [DW-1:0] regModel [0:NREG-1];

    regfile_wb_sched #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_stall (issue_stall),
        .wb0_valid   (wb0_valid),
        .wb0_rd      (wb0_rd),
        .wb0_data    (wb0_data),
        .wb0_ready   (wb0_ready),
        .wb1_valid   (wb1_valid),
        .wb1_rd      (wb1_rd),
        .wb1_data    (wb1_data),
        .wb1_ready   (wb1_ready),
        .rf_r        (rf_r),
        .rf_rd       (rf_rd),
        .rf_din      (rf_din),
        .busy_mask   (busy_mask),
        .wb_err      (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RegFile stand-in: commits rf_din to rf_rd at the end of a write cycle.
    always @(posedge clk) begin
        if (!rf_r) begin
            regModel[rf_rd] <= rf_din;
        end
    end

    // Advance one clock and settle just after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int issueList [5];
        checks = 0;
        errors = 0;
        issueList[0] = 1; issueList[1] = 2; issueList[2] = 3;
        issueList[3] = 4; issueList[4] = 6;

        rst = 1'b1;
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
        wb0_valid = 1'b0; wb0_rd = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_rd = '0; wb1_data = '0;

        // Reset state.
        applyStimulus();
        #1;
        checkOutput("reset_rf_r",   32'(rf_r), 32'd1);
        checkOutput("reset_rf_rd",  32'(rf_rd), 32'd0);
        checkOutput("reset_rf_din", rf_din, 32'd0);
        checkOutput("reset_busy",   busy_mask, 32'd0);
        checkOutput("reset_wb_err", 32'(wb_err), 32'd0);
        checkOutput("reset_ready0", 32'(wb0_ready), 32'd0);
        checkOutput("reset_ready1", 32'(wb1_ready), 32'd0);
        rst = 1'b0;
        applyStimulus();

        // Issue rd=5, then write it back through wb0.
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        checkOutput("issue5_stall", 32'(issue_stall), 32'd0);
        applyStimulus();
        issue_valid = 1'b0; issue_rd = '0;
        checkOutput("issue5_busy", busy_mask, 32'h0000_0020);
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'd150;
        #1;
        checkOutput("wb5_ready0", 32'(wb0_ready), 32'd1);
        checkOutput("wb5_ready1", 32'(wb1_ready), 32'd0);
        applyStimulus();
        wb0_valid = 1'b0;
        checkOutput("wb5_rf_r",   32'(rf_r), 32'd0);
        checkOutput("wb5_rf_rd",  32'(rf_rd), 32'd5);
        checkOutput("wb5_rf_din", rf_din, 32'd150);
        checkOutput("wb5_busy_during", busy_mask, 32'h0000_0020);
        applyStimulus();
        checkOutput("wb5_busy_after", busy_mask, 32'd0);
        checkOutput("wb5_rf_r_idle", 32'(rf_r), 32'd1);
        checkOutput("wb5_rf_rd_hold", 32'(rf_rd), 32'd5);
        checkOutput("wb5_wb_err", 32'(wb_err), 32'd0);

        // RAW hazard on reg 10, resolved by a load-unit write of 300.
        issue_valid = 1'b1; issue_rd = 5'd10;
        applyStimulus();
        issue_rd = 5'd0; issue_rs1 = 5'd10;
        #1;
        checkOutput("raw_stall_a", 32'(issue_stall), 32'd1);
        applyStimulus();
        checkOutput("raw_stall_b", 32'(issue_stall), 32'd1);
        wb1_valid = 1'b1; wb1_rd = 5'd10; wb1_data = 32'd300;
        #1;
        checkOutput("raw_ready1", 32'(wb1_ready), 32'd1);
        checkOutput("raw_stall_c", 32'(issue_stall), 32'd1);
        applyStimulus();
        wb1_valid = 1'b0;
        checkOutput("raw_rf_r", 32'(rf_r), 32'd0);
        checkOutput("raw_stall_commit", 32'(issue_stall), 32'd1);
        applyStimulus();
        checkOutput("raw_stall_release", 32'(issue_stall), 32'd0);
        checkOutput("raw_rs1_value", regModel[10], 32'd300);
        applyStimulus();
        issue_valid = 1'b0; issue_rs1 = '0;

        // Make regs 1,2,3,4,6 pending, then alternate both requesters.
        foreach (issueList[i]) begin
            issue_valid = 1'b1; issue_rd = AW'(issueList[i]);
            applyStimulus();
        end
        issue_valid = 1'b0; issue_rd = '0;
        checkOutput("rr_busy_set", busy_mask, 32'h0000_005E);

        wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'h11;
        wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'h22;
        #1;
        checkOutput("rr_g1_ready0", 32'(wb0_ready), 32'd1);
        checkOutput("rr_g1_ready1", 32'(wb1_ready), 32'd0);
        applyStimulus();
        wb0_rd = 5'd3; wb0_data = 32'h33;
        #1;
        checkOutput("rr_g2_ready1", 32'(wb1_ready), 32'd1);
        checkOutput("rr_g2_ready0", 32'(wb0_ready), 32'd0);
        checkOutput("rr_g2_rf_rd", 32'(rf_rd), 32'd1);
        applyStimulus();
        wb1_rd = 5'd4; wb1_data = 32'h44;
        #1;
        checkOutput("rr_g3_ready0", 32'(wb0_ready), 32'd1);
        checkOutput("rr_g3_rf_rd", 32'(rf_rd), 32'd2);
        applyStimulus();
        wb0_rd = 5'd6; wb0_data = 32'h66;
        #1;
        checkOutput("rr_g4_ready1", 32'(wb1_ready), 32'd1);
        checkOutput("rr_g4_rf_rd", 32'(rf_rd), 32'd3);
        applyStimulus();
        wb1_valid = 1'b0;
        #1;
        checkOutput("rr_g5_ready0", 32'(wb0_ready), 32'd1);
        checkOutput("rr_g5_rf_rd", 32'(rf_rd), 32'd4);
        applyStimulus();
        wb0_valid = 1'b0;
        checkOutput("rr_g6_rf_rd", 32'(rf_rd), 32'd6);
        checkOutput("rr_g6_rf_din", rf_din, 32'h66);
        applyStimulus();
        checkOutput("rr_busy_clear", busy_mask, 32'd0);
        checkOutput("rr_wb_err", 32'(wb_err), 32'd0);
        checkOutput("rr_reg2_value", regModel[2], 32'h22);
        checkOutput("rr_reg3_value", regModel[3], 32'h33);

        // A write to reg 0 is consumed without reaching the RegFile.
        wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'd53;
        #1;
        checkOutput("r0_ready1", 32'(wb1_ready), 32'd1);
        applyStimulus();
        wb1_valid = 1'b0;
        checkOutput("r0_rf_r", 32'(rf_r), 32'd1);
        checkOutput("r0_rf_rd_hold", 32'(rf_rd), 32'd6);

        // A write to a register that is not busy sets wb_err but is still performed.
        wb0_valid = 1'b1; wb0_rd = 5'd25; wb0_data = 32'd77;
        applyStimulus();
        wb0_valid = 1'b0;
        checkOutput("err_rf_r", 32'(rf_r), 32'd0);
        checkOutput("err_rf_rd", 32'(rf_rd), 32'd25);
        checkOutput("err_wb_err", 32'(wb_err), 32'd1);
        applyStimulus();
        checkOutput("err_reg25_value", regModel[25], 32'd77);
        checkOutput("err_busy", busy_mask, 32'd0);

        // Set and clear reg 7 on the same edge: the new issue wins.
        wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'd9;
        applyStimulus();
        wb0_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        checkOutput("setclr_rf_r", 32'(rf_r), 32'd0);
        checkOutput("setclr_stall", 32'(issue_stall), 32'd0);
        applyStimulus();
        issue_valid = 1'b0; issue_rd = '0;
        checkOutput("setclr_busy", busy_mask, 32'h0000_0080);

        // Reset with a requester waiting: no write; it retries after release.
        wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'd5;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_ready0", 32'(wb0_ready), 32'd0);
        applyStimulus();
        checkOutput("rst_mid_rf_r", 32'(rf_r), 32'd1);
        checkOutput("rst_mid_busy", busy_mask, 32'd0);
        checkOutput("rst_mid_wb_err", 32'(wb_err), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_rel_ready0", 32'(wb0_ready), 32'd1);
        applyStimulus();
        wb0_valid = 1'b0;
        checkOutput("rst_rel_rf_r", 32'(rf_r), 32'd0);
        checkOutput("rst_rel_rf_rd", 32'(rf_rd), 32'd7);
        checkOutput("rst_rel_rf_din", rf_din, 32'd5);
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
